otter_mmio_io: RTL and testbench
================================

// Module: otter_mmio_io
// PURPOSE
// Memory-mapped IO peripheral block fed by the data-port IO path of the OTTER memory: it
// consumes IO_WR/address/write data for addresses >= 0x0001_0000 and returns IO_OUT, which
// drives the memory's IO_IN (captured there on negedge when the data read enable is high).
// Holds LED and seven-segment registers, debounces switches, and provides a 32-bit timer
// with a one-cycle interrupt pulse.
// PARAMETERS
// DEBOUNCE_CYCLES  250000  consecutive stable cycles before a switch change is committed
// REFRESH_DIV      100000  cycles each seven-segment digit is driven before advancing
// PORTS
// CLK        in   1   system clock; all state updates on posedge
// RST        in   1   synchronous, active-high reset
// IO_ADDR    in   32  byte address from the data port
// IO_WR      in   1   IO write strobe (already qualified to the external address range)
// IO_DIN     in   32  write data
// SWITCHES   in   16  raw, asynchronous board switches
// IO_OUT     out  32  read data for the decoded address (combinational from registered state)
// LEDS       out  16  LED register
// SSEG_AN    out  4   digit anodes, active-low, one-hot-low while scanning
// SSEG_CA    out  7   segments {g..a}, active-low
// TIMER_INTR out  1   one-cycle pulse on timer expiry
// BEHAVIOUR
// Map (full 32-bit match, IO_ADDR[1:0] must be 00, else unmapped):
//  0x1100_0000 SW     RO  {16'b0, debounced switches}
//  0x1100_0020 LED    RW  [15:0]
//  0x1100_0040 SSEG   RW  [15:0], four hex digits, digit 0 = [3:0]
//  0x1100_0060 TCTRL  RW  bit0 EN, bit1 AUTO_RELOAD; any write clears TCOUNT to 0
//  0x1100_0064 TLIMIT RW  32-bit
//  0x1100_0068 TCOUNT RO  32-bit
//  0x1100_006C TSTAT  bit0 EXPIRED sticky; write with DIN[0]=1 clears it
// - Writes take effect at the posedge where IO_WR=1; unmapped writes ignored; reads of
//   unmapped/write-only bits return 0. IO_OUT has zero-cycle latency from IO_ADDR.
// - Reset: LEDS=0, SSEG=0, TCTRL=0, TLIMIT=0, TCOUNT=0, EXPIRED=0, TIMER_INTR=0,
//   debounced SW=0, scan digit=0, refresh counter=0; SSEG_AN=4'b1111, SSEG_CA=7'h7F while
//   RST high. Reset mid-operation aborts debounce/scan/timer state to these values.
// - Switch path: 2-flop synchronizer, then single shared counter: if synchronized vector !=
//   last sample, counter<=0 and sample<=new; else counter increments; on counter reaching
//   DEBOUNCE_CYCLES-1 the sample is committed to SW. Latency: 2 + DEBOUNCE_CYCLES cycles.
// - Seven-seg: refresh counter 0..REFRESH_DIV-1; on wrap digit index advances 0->1->2->3->0.
//   SSEG_AN = ~(1<<digit); SSEG_CA = active-low hex decode of SSEG[4*digit+3:4*digit],
//   registered (one-cycle lag vs. digit index is acceptable, anode and cathode must switch
//   in the same cycle).
// - Timer states: IDLE (EN=0) and RUN (EN=1). RUN: TCOUNT increments each cycle; when
//   TCOUNT==TLIMIT and TLIMIT!=0: EXPIRED<=1, TIMER_INTR=1 next cycle only, TCOUNT<=0;
//   if AUTO_RELOAD=0 EN<=0 (-> IDLE), else stay RUN. TLIMIT=0: no expiry, TCOUNT wraps at
//   2^32. Equality compare only: lowering TLIMIT below TCOUNT causes wrap before expiry.
// - Simultaneous: expiry set beats TSTAT clear in same cycle; a TCTRL write in the expiry
//   cycle wins (TCOUNT<=0, EN/AUTO from DIN) but EXPIRED/INTR still fire.
// TESTING
// - Write 0x1100_0020 <- 0xA5A5, then read -> IO_OUT=0x0000A5A5, LEDS=0xA5A5 next cycle.
// - SWITCHES 0->0x0003 steady (DEBOUNCE_CYCLES=4) -> SW reads 0x3 after 6 cycles; a glitch
//   shorter than 4 cycles leaves SW=0.
// - SSEG=0x1234, REFRESH_DIV=2 -> SSEG_AN cycles 1110,1101,1011,0111 every 2 cycles with
//   CA = 7'h19(4),7'h30(3),7'h24(2),7'h79(1) per digit.
// - TLIMIT=5, TCTRL=0x3 -> TIMER_INTR pulses every 6 cycles, TSTAT=1; write TSTAT=1 -> 0.
// - TLIMIT=3, TCTRL=0x1 -> one pulse, then TCTRL reads 0x0, TCOUNT=0; RST mid-count
//   -> all outputs to reset values; unmapped read 0x1100_0004 -> 0.

Source files
------------

// File: rtl/otter_mmio_io_if.sv
// Data-port IO bus between the OTTER memory and the MMIO peripheral block.
// The memory side drives the address, strobe and write data; the peripheral side returns read data.
interface otter_mmio_io_if;
  logic [31:0] IO_ADDR;
  logic        IO_WR;
  logic [31:0] IO_DIN;
  logic [31:0] IO_OUT;

  modport master (output IO_ADDR, output IO_WR, output IO_DIN, input IO_OUT);
  modport slave  (input IO_ADDR, input IO_WR, input IO_DIN, output IO_OUT);
endinterface

// File: rtl/otter_mmio_io.sv
// OTTER MMIO peripherals: LED and seven-segment registers, debounced switches,
// and a 32-bit timer with sticky expiry flag and a one-cycle interrupt pulse.
module otter_mmio_io #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REFRESH_DIV     = 100000
) (
  input  logic              CLK,
  input  logic              RST,
  otter_mmio_io_if.slave    bus,
  input  logic [15:0]       SWITCHES,
  output logic [15:0]       LEDS,
  output logic [3:0]        SSEG_AN,
  output logic [6:0]        SSEG_CA,
  output logic              TIMER_INTR
);
  localparam logic [31:0] ADDR_SW     = 32'h1100_0000;
  localparam logic [31:0] ADDR_LED    = 32'h1100_0020;
  localparam logic [31:0] ADDR_SSEG   = 32'h1100_0040;
  localparam logic [31:0] ADDR_TCTRL  = 32'h1100_0060;
  localparam logic [31:0] ADDR_TLIMIT = 32'h1100_0064;
  localparam logic [31:0] ADDR_TCOUNT = 32'h1100_0068;
  localparam logic [31:0] ADDR_TSTAT  = 32'h1100_006C;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_DIV - 1);

  typedef enum logic {T_IDLE, T_RUN} timer_state_t;

  logic wr_led, wr_sseg, wr_tctrl, wr_tlimit, wr_tstat;
  assign wr_led    = bus.IO_WR && (bus.IO_ADDR == ADDR_LED);
  assign wr_sseg   = bus.IO_WR && (bus.IO_ADDR == ADDR_SSEG);
  assign wr_tctrl  = bus.IO_WR && (bus.IO_ADDR == ADDR_TCTRL);
  assign wr_tlimit = bus.IO_WR && (bus.IO_ADDR == ADDR_TLIMIT);
  assign wr_tstat  = bus.IO_WR && (bus.IO_ADDR == ADDR_TSTAT);

  logic [15:0] led_reg, sseg_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      led_reg  <= '0;
      sseg_reg <= '0;
    end else begin
      if (wr_led)  led_reg  <= bus.IO_DIN[15:0];
      if (wr_sseg) sseg_reg <= bus.IO_DIN[15:0];
    end
  end

  // Switch path: one counter shared by all bits, restarted on any change of the vector.
  logic [15:0]     sw_meta_reg, sw_sync_reg, sw_sample_reg, sw_reg;
  logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
  logic            sw_change;

  always_comb begin
    sw_change   = (sw_sync_reg != sw_sample_reg);
    db_cnt_next = db_cnt_reg;
    if (sw_change)                 db_cnt_next = '0;
    else if (db_cnt_reg != DB_LAST) db_cnt_next = db_cnt_reg + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_meta_reg   <= '0;
      sw_sync_reg   <= '0;
      sw_sample_reg <= '0;
      sw_reg        <= '0;
      db_cnt_reg    <= '0;
    end else begin
      sw_meta_reg   <= SWITCHES;
      sw_sync_reg   <= sw_meta_reg;
      sw_sample_reg <= sw_sync_reg;
      db_cnt_reg    <= db_cnt_next;
      if (!sw_change && (db_cnt_next == DB_LAST)) sw_reg <= sw_sample_reg;
    end
  end

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'h40;  4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;  4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;  4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;  4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;  4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;  4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;  4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;  default: hex_decode = 7'h0E;
    endcase
  endfunction

  logic [RF_W-1:0] ref_cnt_reg;
  logic [1:0]      digit_reg;
  logic [3:0]      an_reg;
  logic [6:0]      ca_reg;
  logic [3:0]      nibble;

  assign nibble = sseg_reg[{digit_reg, 2'b00} +: 4];

  // Anode and cathode are both registered from the same digit index so they switch together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ref_cnt_reg <= '0;
      digit_reg   <= '0;
      an_reg      <= 4'hF;
      ca_reg      <= 7'h7F;
    end else begin
      if (ref_cnt_reg == RF_LAST) begin
        ref_cnt_reg <= '0;
        digit_reg   <= digit_reg + 2'd1;
      end else begin
        ref_cnt_reg <= ref_cnt_reg + 1'b1;
      end
      an_reg <= ~(4'b0001 << digit_reg);
      ca_reg <= hex_decode(nibble);
    end
  end

  timer_state_t state_reg, state_next;
  logic         auto_reg, auto_next;
  logic [31:0]  limit_reg, limit_next;
  logic [31:0]  count_reg, count_next;
  logic         expired_reg, expired_next;
  logic         intr_reg;
  logic         expire;

  assign expire = (state_reg == T_RUN) && (limit_reg != '0) && (count_reg == limit_reg);

  always_comb begin
    state_next   = state_reg;
    auto_next    = auto_reg;
    limit_next   = limit_reg;
    count_next   = count_reg;
    expired_next = expired_reg;
    case (state_reg)
      T_RUN: begin
        count_next = count_reg + 32'd1;
        if (expire) begin
          count_next = '0;
          if (!auto_reg) state_next = T_IDLE;
        end
      end
      default: ;
    endcase
    // Expiry set has priority over a same-cycle status clear; a control write overrides the counter.
    if (wr_tstat && bus.IO_DIN[0]) expired_next = 1'b0;
    if (expire)                    expired_next = 1'b1;
    if (wr_tctrl) begin
      count_next = '0;
      state_next = bus.IO_DIN[0] ? T_RUN : T_IDLE;
      auto_next  = bus.IO_DIN[1];
    end
    if (wr_tlimit) limit_next = bus.IO_DIN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= T_IDLE;
      auto_reg    <= 1'b0;
      limit_reg   <= '0;
      count_reg   <= '0;
      expired_reg <= 1'b0;
      intr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      auto_reg    <= auto_next;
      limit_reg   <= limit_next;
      count_reg   <= count_next;
      expired_reg <= expired_next;
      intr_reg    <= expire;
    end
  end

  always_comb begin
    bus.IO_OUT = '0;
    case (bus.IO_ADDR)
      ADDR_SW:     bus.IO_OUT = {16'h0000, sw_reg};
      ADDR_LED:    bus.IO_OUT = {16'h0000, led_reg};
      ADDR_SSEG:   bus.IO_OUT = {16'h0000, sseg_reg};
      ADDR_TCTRL:  bus.IO_OUT = {30'd0, auto_reg, state_reg == T_RUN};
      ADDR_TLIMIT: bus.IO_OUT = limit_reg;
      ADDR_TCOUNT: bus.IO_OUT = count_reg;
      ADDR_TSTAT:  bus.IO_OUT = {31'd0, expired_reg};
      default:     bus.IO_OUT = '0;
    endcase
  end

  assign LEDS       = led_reg;
  assign SSEG_AN    = an_reg;
  assign SSEG_CA    = ca_reg;
  assign TIMER_INTR = intr_reg;
endmodule

// File: tb/tb_otter_mmio_io.sv
// Randomized scoreboard bench for otter_mmio_io against a cycle-level behavioural model
// of the register map, switch debouncing, display scan and timer.
module tb_otter_mmio_io;
  localparam int DB   = 4;
  localparam int RDIV = 2;

  localparam logic [31:0] A_SW     = 32'h1100_0000;
  localparam logic [31:0] A_LED    = 32'h1100_0020;
  localparam logic [31:0] A_SSEG   = 32'h1100_0040;
  localparam logic [31:0] A_TCTRL  = 32'h1100_0060;
  localparam logic [31:0] A_TLIMIT = 32'h1100_0064;
  localparam logic [31:0] A_TCOUNT = 32'h1100_0068;
  localparam logic [31:0] A_TSTAT  = 32'h1100_006C;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] SWITCHES;
  logic [15:0] LEDS;
  logic [3:0]  SSEG_AN;
  logic [6:0]  SSEG_CA;
  logic        TIMER_INTR;

  otter_mmio_io_if bus();

  otter_mmio_io #(.DEBOUNCE_CYCLES(DB), .REFRESH_DIV(RDIV)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .SWITCHES(SWITCHES),
    .LEDS(LEDS), .SSEG_AN(SSEG_AN), .SSEG_CA(SSEG_CA), .TIMER_INTR(TIMER_INTR)
  );

  always #5 CLK = ~CLK;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0] addr_list [11] = '{A_SW, A_LED, A_SSEG, A_TCTRL, A_TLIMIT, A_TCOUNT, A_TSTAT,
                                  32'h1100_0004, 32'h1100_0062, 32'h2100_0020, 32'h1100_0021};

  // Reference model state
  int          k;
  logic [15:0] m_led, m_sseg, m_sw;
  logic        m_en, m_auto, m_expired;
  logic [31:0] m_limit, m_count;
  logic [3:0]  e_an;
  logic [6:0]  e_ca;
  logic        e_intr;
  logic [15:0] hist[$];
  bit          started = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];
  bit          rd_valid = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a)
      A_SW:     return {16'h0, m_sw};
      A_LED:    return {16'h0, m_led};
      A_SSEG:   return {16'h0, m_sseg};
      A_TCTRL:  return {30'd0, m_auto, m_en};
      A_TLIMIT: return m_limit;
      A_TCOUNT: return m_count;
      A_TSTAT:  return {31'd0, m_expired};
      default:  return 32'd0;
    endcase
  endfunction

  // Advance the model by one rising edge, using the inputs present at that edge.
  task automatic model_step();
    logic [31:0] a, d;
    logic        w, fire, stable;
    int          dig;
    a = bus.IO_ADDR; d = bus.IO_DIN; w = bus.IO_WR;
    started = 1'b1;
    if (RST) begin
      k = 0; m_led = 0; m_sseg = 0; m_sw = 0; m_en = 0; m_auto = 0; m_expired = 0;
      m_limit = 0; m_count = 0; e_an = 4'hF; e_ca = 7'h7F; e_intr = 0;
      hist.delete();
      for (int i = 0; i < DB + 2; i++) hist.push_back(16'h0);
      return;
    end
    dig  = (k / RDIV) % 4;
    e_an = ~(4'b0001 << dig);
    e_ca = hex_tab[(m_sseg >> (4 * dig)) & 16'hF];
    k++;
    // Debounced value: raw samples two to DB+1 edges old must all agree.
    hist.push_back(SWITCHES);
    if (hist.size() > DB + 2) void'(hist.pop_front());
    stable = 1'b1;
    for (int i = 1; i < DB; i++) if (hist[i] != hist[0]) stable = 1'b0;
    if (stable) m_sw = hist[0];
    fire   = m_en && (m_limit != 0) && (m_count == m_limit);
    e_intr = fire;
    if (m_en) m_count = fire ? 32'd0 : m_count + 32'd1;
    if (fire && !m_auto) m_en = 1'b0;
    if (w && a == A_TSTAT && d[0]) m_expired = 1'b0;
    if (fire) m_expired = 1'b1;
    if (w && a == A_TCTRL) begin m_count = 0; m_en = d[0]; m_auto = d[1]; end
    if (w && a == A_TLIMIT) m_limit = d;
    if (w && a == A_LED)    m_led = d[15:0];
    if (w && a == A_SSEG)   m_sseg = d[15:0];
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.IO_ADDR = a; bus.IO_DIN = d; bus.IO_WR = 1'b1;
    cyc();
    bus.IO_WR = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.IO_ADDR = a; bus.IO_WR = 1'b0;
    exp_q.push_back(m_read(a));
    addr_q.push_back(a);
    rd_valid = 1'b1;
    cyc();
    rd_valid = 1'b0;
  endtask

  // Monitor: continuous outputs every cycle, read data whenever a read is presented.
  always @(negedge CLK) begin
    if (started) begin
      check("LEDS", 32'(LEDS), 32'(m_led));
      check("SSEG_AN", 32'(SSEG_AN), 32'(e_an));
      check("SSEG_CA", 32'(SSEG_CA), 32'(e_ca));
      check("TIMER_INTR", 32'(TIMER_INTR), 32'(e_intr));
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          logic [31:0] ex, ad;
          ex = exp_q.pop_front();
          ad = addr_q.pop_front();
          $display("RD addr=%h data=%h expected=%h", ad, bus.IO_OUT, ex);
          check($sformatf("IO_OUT[%h]", ad), bus.IO_OUT, ex);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; SWITCHES = 16'h0;
    bus.IO_ADDR = 32'h0; bus.IO_WR = 1'b0; bus.IO_DIN = 32'h0;
    cyc(); cyc();
    RST = 1'b0;
    foreach (addr_list[i]) rd(addr_list[i]);

    wr(A_LED, 32'h0000_A5A5);
    rd(A_LED);
    rd(32'h1100_0004);

    wr(A_SSEG, 32'h0000_1234);
    repeat (16) cyc();

    SWITCHES = 16'h0003;
    repeat (8) rd(A_SW);
    SWITCHES = 16'h0005;
    rd(A_SW); rd(A_SW);
    SWITCHES = 16'h0003;
    repeat (6) rd(A_SW);

    wr(A_TLIMIT, 32'd5);
    wr(A_TCTRL, 32'h3);
    repeat (14) rd(A_TCOUNT);
    rd(A_TSTAT);
    wr(A_TSTAT, 32'h1);
    rd(A_TSTAT);

    wr(A_TLIMIT, 32'd3);
    wr(A_TCTRL, 32'h1);
    repeat (7) cyc();
    rd(A_TCTRL); rd(A_TCOUNT); rd(A_TSTAT);

    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 7) == 0) SWITCHES = 16'($urandom_range(0, 3));
      case ($urandom_range(0, 11))
        0:  wr(A_LED, $urandom);
        1:  wr(A_SSEG, $urandom);
        2:  wr(A_TCTRL, $urandom);
        3:  wr(A_TLIMIT, ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 12)));
        4:  wr(A_TSTAT, $urandom);
        5:  wr(addr_list[$urandom_range(7, 10)], $urandom);
        6, 7, 8, 9: rd(addr_list[$urandom_range(0, 10)]);
        default: cyc();
      endcase
    end

    wr(A_TLIMIT, 32'd100);
    wr(A_LED, 32'h0000_00FF);
    wr(A_TCTRL, 32'h1);
    repeat (10) cyc();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    foreach (addr_list[i]) rd(addr_list[i]);

    repeat (3) cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
